chip8_fetch: RTL
================

Name: chip8_fetch

Overview:
- Instruction fetch stage that sits directly downstream of the ROM image loader.
- Waits for `rom_ready`, then reads big-endian 2-byte CHIP-8 opcodes from the 4 KiB byte memory at the program counter.
- Presents each opcode to decode/execute over a valid/ready handshake.
- Owns the PC; applies jump/load and skip redirects supplied by execute at handshake time.

Parameters:
- ADDR_W, 12, memory address width (4096 bytes)
- PC_RESET, 12'h200, PC value after reset (CHIP-8 program base)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rom_ready  input  1  memory image loaded; fetch may start
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  memory byte address
- mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en
- opcode  output  16  fetched opcode {byte[pc], byte[pc+1]}
- opcode_pc  output  ADDR_W  address of the presented opcode
- opcode_valid  output  1  opcode/opcode_pc valid
- opcode_ready  input  1  consumer accepts opcode
- pc_load  input  1  redirect: next PC = pc_load_addr (sampled only at handshake)
- pc_load_addr  input  ADDR_W  redirect target
- pc_skip  input  1  skip: next PC = pc+4 (sampled only at handshake)
- fetch_fault  output  1  present only with CHIP8_FETCH_ALIGN_CHECK_EN

Behaviour:
- One clock (clk_in). Reset (rst_in) is synchronous and active-high. Reset has priority over everything, including mid-fetch and mid-hold.
- Reset values:
  - state = WAIT_ROM, pc = PC_RESET
  - opcode = 0, opcode_pc = 0, opcode_valid = 0
  - mem_rd_en = 0, mem_addr = 0, fetch_fault = 0
- FSM states are WAIT_ROM, REQ_HI, REQ_LO, CAPTURE, HOLD and FAULT (FAULT only with the macro). Transitions:
  - WAIT_ROM: no reads. When rom_ready=1, go to REQ_HI.
  - After leaving WAIT_ROM, rom_ready is ignored; it is re-examined only after reset.
  - REQ_HI: mem_rd_en=1, mem_addr=pc. Go to REQ_LO.
  - REQ_LO: mem_rd_en=1, mem_addr=(pc+1) mod 4096. Latch mem_rd_data into opcode[15:8]. Go to CAPTURE.
  - CAPTURE: mem_rd_en=0. Latch mem_rd_data into opcode[7:0]. Set opcode_pc=pc and opcode_valid=1 (registered, visible next cycle). Go to HOLD.
  - HOLD: opcode, opcode_pc and opcode_valid are stable and mem_rd_en=0 while opcode_ready=0.
  - HOLD, on opcode_valid & opcode_ready: opcode_valid=0 next cycle; go to REQ_HI. Next pc is:
    - pc_load=1: pc_load_addr (pc_load wins over pc_skip when both are asserted)
    - else pc_skip=1: pc+4
    - else: pc+2
- Latency: REQ_HI entry to opcode_valid high = 3 cycles. Throughput = 1 opcode per 4 cycles when ready is held high.
- Arithmetic: all PC math is ADDR_W bits and wraps modulo 4096 (0xFFE+2=0x000, 0xFFE+4=0x002, 0xFFF+1=0x000).
- Odd PCs are legal without the macro and fetch bytes pc and pc+1 unchanged.
- pc_load and pc_skip outside a HOLD handshake cycle are ignored (no effect, no latching).
- mem_rd_data is don't-care outside the cycles after REQ_HI and REQ_LO.

Optional Feature:
- Macro: CHIP8_FETCH_ALIGN_CHECK_EN.
- Defined:
  - The fetch_fault port exists.
  - If the next-PC computed at a handshake is odd, go to FAULT instead of REQ_HI. fetch_fault=1 is sticky until reset.
  - In FAULT: opcode_valid=0 and mem_rd_en=0.
  - A PC_RESET that is odd enters FAULT from WAIT_ROM on rom_ready.
- Undefined: the port and the FAULT state are absent, and odd addresses are fetched normally.

Decomposition:
- Shared package chip8_pkg holds:
  - addr_t (logic [11:0]) and opcode_t (logic [15:0])
  - MEM_SIZE=4096
  - PC_RESET_DEFAULT=12'h200
  - fetch_state_t enum
- No sub-module is required.
- Next-PC selection (load/skip/increment with wrap) is written as a function in chip8_pkg so execute can reuse it.

Test Plan:
- Start-up:
  - Stimulus: rom_ready=0 for 10 cycles, then 1; mem[0x200]=0x12, mem[0x201]=0x34.
  - Response: no mem_rd_en while rom_ready=0; then addr 0x200, then 0x201; opcode_valid rises 3 cycles after REQ_HI with opcode=0x1234, opcode_pc=0x200.
- Backpressure:
  - Stimulus: opcode_ready=0 for 5 cycles while valid, then 1.
  - Response: opcode stable and no mem reads while stalled; next REQ_HI addresses 0x202.
- Redirect:
  - Stimulus 1: pc_skip at the handshake on 0x200.
  - Response 1: next opcode_pc=0x204.
  - Stimulus 2: pc_load=1 with pc_load_addr=0x300 and pc_skip=1 together.
  - Response 2: next opcode_pc=0x300.
  - Stimulus 3: pc_load asserted while in REQ_LO.
  - Response 3: ignored.
- Wrap:
  - Stimulus: load 0xFFE.
  - Response: reads 0xFFE/0xFFF, then next fetch from 0x000.
  - Stimulus (macro off): load 0xFFF.
  - Response: reads 0xFFF then 0x000; opcode={mem[0xFFF],mem[0x000]}.
- Reset mid-fetch:
  - Stimulus: rst_in for 1 cycle during REQ_LO, rom_ready still 1.
  - Response: outputs return to reset values; REQ_HI at 0x200 follows.
- Macro on:
  - Stimulus: pc_load_addr=0x301 at a handshake.
  - Response: fetch_fault=1 next cycle, no further mem_rd_en or opcode_valid until reset.

Source files
------------

// File: rtl/chip8_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : chip8_pkg                                                  |
// | Description : Shared types, constants and next-PC helper for the CHIP-8  |
// |               instruction fetch/execute path.                            |
// | Options     : CHIP8_FETCH_ALIGN_CHECK_EN adds the FAULT fetch state.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package chip8_pkg;

    localparam int MEM_SIZE = 4096;

    typedef logic [11:0] addr_t;
    typedef logic [15:0] opcode_t;

    localparam addr_t PC_RESET_DEFAULT = 12'h200;

    typedef enum logic [2:0] {
        WAIT_ROM = 3'd0,
        REQ_HI   = 3'd1,
        REQ_LO   = 3'd2,
        CAPTURE  = 3'd3,
        HOLD     = 3'd4
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
        ,
        FAULT    = 3'd5
`endif
    } fetch_state_t;

    // Next program counter after an accepted opcode. A load beats a skip;
    // all arithmetic is 12-bit so it wraps modulo the 4 KiB address space.
    function automatic addr_t next_pc(
        input addr_t pc,
        input logic  load,
        input addr_t load_addr,
        input logic  skip
    );
        addr_t w_result;
        if (load) begin
            w_result = load_addr;
        end else if (skip) begin
            w_result = pc + 12'd4;
        end else begin
            w_result = pc + 12'd2;
        end
        return w_result;
    endfunction

endpackage : chip8_pkg

`default_nettype wire

// File: rtl/chip8_fetch.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : chip8_fetch                                                |
// | Description : CHIP-8 instruction fetch. Waits for the ROM image, reads   |
// |               big-endian 2-byte opcodes from byte memory at the PC and   |
// |               offers them over valid/ready. Owns the PC and applies      |
// |               load/skip redirects from execute at handshake time.        |
// | Ports       : clk_in/rst_in        clock, synchronous active-high reset  |
// |               rom_ready            memory image loaded                   |
// |               mem_rd_en/mem_addr   byte read request                     |
// |               mem_rd_data          read data, 1 cycle after request      |
// |               opcode/opcode_pc     presented opcode and its address      |
// |               opcode_valid/ready   handshake to decode/execute           |
// |               pc_load/_addr/skip   redirect, sampled at handshake only   |
// |               fetch_fault          odd-PC fault (option only)            |
// | Options     : CHIP8_FETCH_ALIGN_CHECK_EN enables the alignment check,    |
// |               the FAULT state and the fetch_fault port.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module chip8_fetch
    import chip8_pkg::*;
#(
    // PC arithmetic uses the package addr_t, so ADDR_W is expected to stay 12.
    parameter int    ADDR_W   = $clog2(MEM_SIZE),
    parameter addr_t PC_RESET = PC_RESET_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rom_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [15:0]       opcode,
    output logic [ADDR_W-1:0] opcode_pc,
    output logic              opcode_valid,
    input  logic              opcode_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    input  logic              pc_skip
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    ,
    output logic              fetch_fault
`endif
);

    fetch_state_t r_state;
    addr_t        r_pc;
    opcode_t      r_opcode;
    addr_t        r_opcode_pc;
    logic         r_opcode_valid;
    logic         r_mem_rd_en;
    addr_t        r_mem_addr;
    addr_t        w_next_pc;

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    logic         r_fault;
    assign fetch_fault = r_fault;
`endif

    // Only meaningful in HOLD with opcode_ready high; elsewhere it is unused,
    // which is what makes redirects outside a handshake have no effect.
    assign w_next_pc = next_pc(r_pc, pc_load, pc_load_addr, pc_skip);

    assign mem_rd_en    = r_mem_rd_en;
    assign mem_addr     = r_mem_addr;
    assign opcode       = r_opcode;
    assign opcode_pc    = r_opcode_pc;
    assign opcode_valid = r_opcode_valid;

    // Memory request outputs are registered, so they are set up on the edge
    // that enters REQ_HI / REQ_LO and dropped on the edge that enters CAPTURE.
    // Read data for a request arrives in the following state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= WAIT_ROM;
            r_pc           <= PC_RESET;
            r_opcode       <= '0;
            r_opcode_pc    <= '0;
            r_opcode_valid <= 1'b0;
            r_mem_rd_en    <= 1'b0;
            r_mem_addr     <= '0;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
            r_fault        <= 1'b0;
`endif
        end else begin
            case (r_state)
                WAIT_ROM: begin
                    if (rom_ready) begin
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
                        if (r_pc[0]) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else
`endif
                        begin
                            r_state     <= REQ_HI;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= r_pc;
                        end
                    end
                end

                REQ_HI: begin
                    r_mem_addr <= r_pc + 12'd1;
                    r_state    <= REQ_LO;
                end

                REQ_LO: begin
                    r_mem_rd_en     <= 1'b0;
                    r_opcode[15:8]  <= mem_rd_data;
                    r_state         <= CAPTURE;
                end

                CAPTURE: begin
                    r_opcode[7:0]  <= mem_rd_data;
                    r_opcode_pc    <= r_pc;
                    r_opcode_valid <= 1'b1;
                    r_state        <= HOLD;
                end

                HOLD: begin
                    // opcode_valid is always high here, so ready alone
                    // completes the handshake.
                    if (opcode_ready) begin
                        r_opcode_valid <= 1'b0;
                        r_pc           <= w_next_pc;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
                        if (w_next_pc[0]) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else
`endif
                        begin
                            r_state     <= REQ_HI;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= w_next_pc;
                        end
                    end
                end

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
                FAULT: begin
                    // Terminal until reset; outputs already quiet.
                    r_state <= FAULT;
                end
`endif

                default: begin
                    r_state <= WAIT_ROM;
                end
            endcase
        end
    end

endmodule : chip8_fetch

`default_nettype wire
